fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter INSTRSZ, default 32, meaning instruction width.
REQ-002 The block SHALL have parameter ADDRSZ, default 64, meaning PC and bus address width.
REQ-003 The block SHALL have parameter BUSW, default 64, meaning memory return width, holding two instructions.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries, a power of two, at least 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port entry, input, ADDRSZ bits: start PC, sampled while reset is high.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: a branch or jump target is present this cycle.
REQ-009 The block SHALL have port redirect_pc, input, ADDRSZ bits: the new PC; bits [1:0] are 0.
REQ-010 The block SHALL have port mem_req, output, 1 bit: memory read request.
REQ-011 The block SHALL have port mem_addr, output, ADDRSZ bits: request address, 8-byte aligned (bits [2:0] = 0).
REQ-012 The block SHALL have port mem_ack, input, 1 bit: returned data is valid this cycle.
REQ-013 The block SHALL have port mem_data, input, BUSW bits: returned doubleword; [31:0] is at the lower address.
REQ-014 The block SHALL have port instr, output, INSTRSZ bits: the instruction word, driving the decoder instr input.
REQ-015 The block SHALL have port instr_pc, output, ADDRSZ bits: the PC of instr.
REQ-016 The block SHALL have port instr_valid, output, 1 bit: instr and instr_pc are valid.
REQ-017 The block SHALL have port instr_ready, input, 1 bit: the downstream stage accepts instr this cycle.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ and DISCARD.
REQ-019 IDLE SHALL go to REQ when the queue's free entries are at least 2.
REQ-020 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal {fetch_pc[ADDRSZ-1:3], 3'b000}; both SHALL hold stable until mem_ack.
REQ-021 On a REQ-state mem_ack with no redirect, if fetch_pc[2]=0 the block SHALL push mem_data[31:0] at fetch_pc and then mem_data[63:32] at fetch_pc+4.
REQ-022 On that mem_ack, if fetch_pc[2]=1 the block SHALL push only mem_data[63:32] at fetch_pc.
REQ-023 On that mem_ack, fetch_pc SHALL advance to the next 8-byte boundary and the FSM SHALL return to IDLE.
REQ-024 Latency SHALL be: mem_ack in cycle N gives instr_valid=1 in cycle N+1, with no combinational path from mem_data to instr.
REQ-025 A pop SHALL occur exactly when instr_valid & instr_ready; the queue SHALL be first-in first-out.
REQ-026 A push and a pop in the same cycle SHALL both take effect; count = count + pushes - pop.
REQ-027 Queue full: the FSM SHALL NOT leave IDLE, and a push SHALL never be lost.
REQ-028 Queue empty: instr_valid SHALL be 0; instr and instr_pc are don't-care.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 fetch_pc SHALL wrap modulo 2^ADDRSZ.
REQ-031 On redirect_valid, the next cycle SHALL have an empty queue, instr_valid=0, and fetch_pc=redirect_pc.
REQ-032 A pop handshake in the redirect cycle SHALL count as consumed.
REQ-033 A redirect in IDLE SHALL leave the FSM in IDLE.
REQ-034 A redirect in REQ without mem_ack SHALL move the FSM to DISCARD with mem_req held at 1 at the old address.
REQ-035 A redirect in REQ with mem_ack SHALL discard the data and move the FSM to IDLE.
REQ-036 DISCARD SHALL drop the returned data on mem_ack and go to IDLE.
REQ-037 A further redirect while in DISCARD SHALL update fetch_pc only.
REQ-038 mem_ack outside REQ/DISCARD SHALL be ignored.

Reset
REQ-039 While reset=1, the block SHALL set state=IDLE, fetch_pc=entry, queue empty, mem_req=0, instr_valid=0, and mem_addr, instr and instr_pc to 0.
REQ-040 Reset SHALL have priority over redirect_valid and mem_ack.
REQ-041 A reset during REQ/DISCARD SHALL abandon the request, and the late mem_ack SHALL be ignored per REQ-038.

Structure
REQ-042 Package fetch_pkg SHALL hold the state enum (IDLE, REQ, DISCARD) and the default parameter constants.
REQ-043 The queue SHALL be sub-module fetch_fifo: dual-push, single-pop, width ADDRSZ+INSTRSZ, synchronous flush input.

Verification
REQ-044 Scenario, aligned fetch: entry=0x1000; the bench acks with data 0x00500093_00000013 -> mem_addr=0x1000; then instr=0x00000013 at pc 0x1000, then 0x00500093 at pc 0x1004, then the next mem_addr=0x1008.
REQ-045 Scenario, odd start: redirect_pc=0x2004; the bench acks with data 0xAAAAAAAA_BBBBBBBB -> mem_addr=0x2000; one entry is pushed (0xAAAAAAAA at pc 0x2004); the next mem_addr=0x2008.
REQ-046 Scenario, backpressure: instr_ready=0 for 10 cycles with immediate acks -> count stops at 4, mem_req stays 0 after the queue fills, no entry is lost, and order is preserved on release.
REQ-047 Scenario, redirect mid-request: redirect to 0x3000 in REQ, ack 3 cycles later -> that ack's data is never output; the next mem_addr=0x3000.
REQ-048 Scenario, simultaneous events: a redirect, a pop and a mem_ack in one cycle -> the next cycle has instr_valid=0, the queue empty and fetch_pc=redirect_pc.
REQ-049 Scenario, reset mid-REQ: assert reset, deassert it, then the old request's ack arrives -> the ack is ignored and the first request after reset is at entry.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package fetch_pkg;

  localparam int INSTRSZ_DEF = 32;
  localparam int ADDRSZ_DEF  = 64;
  localparam int BUSW_DEF    = 64;
  localparam int DEPTH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: up to two pushes and one pop per cycle, synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = ADDRSZ_DEF + INSTRSZ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push0,
  input  logic [W-1:0]  din0,
  input  logic          push1,
  input  logic [W-1:0]  din1,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // push1 is only ever asserted together with push0, so din1 lands right after din0.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push0) mem[wr_ptr] <= din0;
      if (push1) mem[wr_ptr + PW'(1)] <= din1;
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests 8-byte lines, splits them into instructions, queues them.
//   state   | meaning
//   IDLE    | no request outstanding; waits for two free queue entries
//   REQ     | read of req_addr outstanding; data is pushed on mem_ack
//   DISCARD | read outstanding but redirected away; data dropped on mem_ack
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int INSTRSZ = INSTRSZ_DEF,
  parameter int ADDRSZ  = ADDRSZ_DEF,
  parameter int BUSW    = BUSW_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDRSZ-1:0]  entry,
  input  logic               redirect_valid,
  input  logic [ADDRSZ-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDRSZ-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [BUSW-1:0]    mem_data,
  output logic [INSTRSZ-1:0] instr,
  output logic [ADDRSZ-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int W  = ADDRSZ + INSTRSZ;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_n;
  logic [ADDRSZ-1:0] fetch_pc, fetch_pc_n;
  logic [ADDRSZ-1:0] req_addr;
  logic [ADDRSZ-1:0] line_addr;
  logic [ADDRSZ-1:0] next_line;
  logic              push0, push1, pop, empty, room;
  logic [W-1:0]      din0, din1, dout;
  logic [CW-1:0]     count;

  assign line_addr = {fetch_pc[ADDRSZ-1:3], 3'b000};
  assign next_line = line_addr + ADDRSZ'(8);
  assign room      = (count <= CW'(DEPTH - 2));
  assign pop       = instr_valid & instr_ready;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    push0      = 1'b0;
    push1      = 1'b0;
    din0       = fetch_pc[2] ? {fetch_pc, mem_data[2*INSTRSZ-1:INSTRSZ]}
                             : {fetch_pc, mem_data[INSTRSZ-1:0]};
    din1       = {fetch_pc + ADDRSZ'(4), mem_data[2*INSTRSZ-1:INSTRSZ]};
    case (state)
      IDLE: begin
        if (redirect_valid) fetch_pc_n = redirect_pc;
        else if (room)      state_n    = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_n = redirect_pc;
          state_n    = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          push0      = 1'b1;
          push1      = ~fetch_pc[2];
          fetch_pc_n = next_line;
          state_n    = IDLE;
        end
      end
      DISCARD: begin
        if (redirect_valid) fetch_pc_n = redirect_pc;
        if (mem_ack)        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // req_addr is captured separately so DISCARD keeps the old address after fetch_pc moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= entry;
      req_addr <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (state == IDLE && state_n == REQ) req_addr <= line_addr;
    end
  end

  assign mem_req  = (state != IDLE);
  assign mem_addr = mem_req ? req_addr : '0;

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push0 (push0),
    .din0  (din0),
    .push1 (push1),
    .din1  (din1),
    .pop   (pop),
    .dout  (dout),
    .empty (empty),
    .count (count)
  );

  assign instr_valid       = ~empty;
  assign {instr_pc, instr} = dout;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a PC-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  // Memory image: each word is a fixed scramble of its own address.
  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF ^ {a[17:2], a[33:18]};
  endfunction

  function automatic logic [63:0] dword(input logic [63:0] a);
    return {word(a + 64'd4), word(a)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset = 1'b1; entry = e; redirect_valid = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_data = '0; instr_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; entry = 64'h1000; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'h8888; mem_ack = 1'b1; mem_data = '1;
    tick; tick;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    n_cmp++; if (mem_addr !== 64'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_cmp++; if (instr_pc !== 64'h0) begin n_bad++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    redirect_valid = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; reset = 1'b0;
    tick;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin n_bad++; $display("FAIL reset_first_req: got req=%b addr=%h want 1/1000", mem_req, mem_addr); end
  endtask

  task automatic test_aligned;
    do_reset(64'h1000);
    tick;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin n_bad++; $display("FAIL aligned_req: got req=%b addr=%h want 1/1000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 64'h00500093_00000013;
    tick;
    mem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h00000013 || instr_pc !== 64'h1000) begin n_bad++; $display("FAIL aligned_first: got v=%b %h @%h want 1 00000013 @1000", instr_valid, instr, instr_pc); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL aligned_idle_after_ack: got %b want 0", mem_req); end
    instr_ready = 1'b1;
    tick;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h00500093 || instr_pc !== 64'h1004) begin n_bad++; $display("FAIL aligned_second: got v=%b %h @%h want 1 00500093 @1004", instr_valid, instr, instr_pc); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h1008) begin n_bad++; $display("FAIL aligned_next_req: got req=%b addr=%h want 1/1008", mem_req, mem_addr); end
    tick;
    instr_ready = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL aligned_drained: got %b want 0", instr_valid); end
  endtask

  task automatic test_odd_start;
    do_reset(64'h5000);
    redirect_valid = 1'b1; redirect_pc = 64'h2004;
    tick;
    redirect_valid = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL odd_idle_redirect: got req=%b want 0", mem_req); end
    tick;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h2000) begin n_bad++; $display("FAIL odd_req: got req=%b addr=%h want 1/2000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 64'hAAAAAAAA_BBBBBBBB;
    tick;
    mem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hAAAAAAAA || instr_pc !== 64'h2004) begin n_bad++; $display("FAIL odd_entry: got v=%b %h @%h want 1 aaaaaaaa @2004", instr_valid, instr, instr_pc); end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL odd_single_push: got valid=%b want 0", instr_valid); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h2008) begin n_bad++; $display("FAIL odd_next_req: got req=%b addr=%h want 1/2008", mem_req, mem_addr); end
  endtask

  task automatic test_backpressure;
    int k;
    do_reset(64'h4000);
    repeat (10) begin
      mem_ack = mem_req; mem_data = dword(mem_addr);
      tick;
    end
    mem_ack = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_full_stall: got req=%b valid=%b want 0/1", mem_req, instr_valid); end
    repeat (3) tick;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL bp_stays_idle: got req=%b want 0", mem_req); end
    k = 0;
    instr_ready = 1'b1;
    for (int c = 0; c < 20 && instr_valid; c++) begin
      n_cmp++; if (instr_pc !== 64'h4000 + 64'(4 * k) || instr !== word(64'h4000 + 64'(4 * k))) begin n_bad++; $display("FAIL bp_order: got %h @%h want %h @%h", instr, instr_pc, word(64'h4000 + 64'(4 * k)), 64'h4000 + 64'(4 * k)); end
      k++;
      tick;
    end
    instr_ready = 1'b0;
    n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL bp_count: got %0d entries want 4", k); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h4010) begin n_bad++; $display("FAIL bp_resume_req: got req=%b addr=%h want 1/4010", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = dword(64'h4010);
    tick;
    mem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 64'h4010 || instr !== word(64'h4010)) begin n_bad++; $display("FAIL bp_resume_data: got v=%b %h @%h want 1 %h @4010", instr_valid, instr, instr_pc, word(64'h4010)); end
  endtask

  task automatic test_redirect_mid;
    do_reset(64'h1000);
    tick;
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick;
    redirect_valid = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin n_bad++; $display("FAIL redir_discard_hold: got req=%b addr=%h want 1/1000", mem_req, mem_addr); end
    tick; tick;
    mem_ack = 1'b1; mem_data = 64'hDEADBEEF_DEADBEEF;
    tick;
    mem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_data_dropped: got valid=%b instr=%h want 0", instr_valid, instr); end
    tick;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h3000) begin n_bad++; $display("FAIL redir_next_req: got req=%b addr=%h want 1/3000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = dword(64'h3000);
    tick;
    mem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 64'h3000 || instr !== word(64'h3000)) begin n_bad++; $display("FAIL redir_new_data: got v=%b %h @%h want 1 %h @3000", instr_valid, instr, instr_pc, word(64'h3000)); end
  endtask

  task automatic test_simultaneous;
    do_reset(64'h1000);
    tick;
    mem_ack = 1'b1; mem_data = dword(64'h1000);
    tick;
    mem_ack = 1'b0;
    tick;
    redirect_valid = 1'b1; redirect_pc = 64'h6000;
    instr_ready = 1'b1; mem_ack = 1'b1; mem_data = dword(64'h1008);
    tick;
    redirect_valid = 1'b0; instr_ready = 1'b0; mem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL simul_flushed: got valid=%b req=%b want 0/0", instr_valid, mem_req); end
    tick;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h6000) begin n_bad++; $display("FAIL simul_next_req: got req=%b addr=%h want 1/6000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = dword(64'h6000);
    tick;
    mem_ack = 1'b0;
    n_cmp++; if (instr_pc !== 64'h6000 || instr !== word(64'h6000)) begin n_bad++; $display("FAIL simul_first_after: got %h @%h want %h @6000", instr, instr_pc, word(64'h6000)); end
  endtask

  task automatic test_reset_mid;
    do_reset(64'h1000);
    tick;
    reset = 1'b1; entry = 64'h7000;
    tick;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_abandon: got req=%b want 0", mem_req); end
    reset = 1'b0;
    mem_ack = 1'b1; mem_data = 64'h12345678_9ABCDEF0;
    tick;
    mem_ack = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h7000 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_late_ack: got req=%b addr=%h valid=%b want 1/7000/0", mem_req, mem_addr, instr_valid); end
  endtask

  // Model: the output stream is consecutive PCs from the last redirect/entry, each carrying word(pc).
  task automatic test_random(input logic [63:0] start, input int cycles);
    logic [63:0] exp_pc;
    logic [63:0] hold_a;
    logic        hold_v;
    int          pops;
    do_reset(start);
    exp_pc = start; hold_v = 1'b0; hold_a = '0; pops = 0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (hold_v) begin
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== hold_a) begin n_bad++; $display("FAIL rand_req_stable: got req=%b addr=%h want 1/%h", mem_req, mem_addr, hold_a); end
      end else if (mem_req) begin
        hold_v = 1'b1; hold_a = mem_addr;
        n_cmp++; if (mem_addr[2:0] !== 3'b000) begin n_bad++; $display("FAIL rand_align: got %h", mem_addr); end
      end
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc    = {32'($urandom), 32'($urandom)} & ~64'h3;
      if ($urandom_range(0, 3) == 0) redirect_pc[63:8] = '1;
      if (mem_req) mem_ack = ($urandom_range(0, 2) == 0);
      else         mem_ack = ($urandom_range(0, 7) == 0);
      mem_data = mem_req ? dword(mem_addr) : {32'($urandom), 32'($urandom)};
      if (instr_valid && instr_ready) begin
        n_cmp++; if (instr_pc !== exp_pc || instr !== word(exp_pc)) begin n_bad++; $display("FAIL rand_stream: got %h @%h want %h @%h", instr, instr_pc, word(exp_pc), exp_pc); end
        exp_pc = exp_pc + 64'd4;
        pops++;
      end
      if (mem_ack) hold_v = 1'b0;
      if (redirect_valid) exp_pc = redirect_pc;
      tick;
    end
    redirect_valid = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    n_cmp++; if (pops < 100) begin n_bad++; $display("FAIL rand_progress: got %0d pops want >= 100", pops); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_aligned;
    test_odd_start;
    test_backpressure;
    test_redirect_mid;
    test_simultaneous;
    test_reset_mid;
    test_random(64'hFFFF_FFFF_FFFF_FFE4, 1500);
    test_random(64'h0000_0000_0001_0000, 1500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
